// File: rtl/gtech_tie_pkg.sv
// rtl/gtech_tie_pkg.sv - shared types and constants for the tie-off net monitor
package gtech_tie_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        CLEAN    = 2'd1,
        FAULT    = 2'd2
    } tie_state_t;

    localparam int DB_W      = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/gtech_tie_sync.sv
// rtl/gtech_tie_sync.sv - two-flop synchroniser with per-bit reset value
module gtech_tie_sync
    import gtech_tie_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Loading the expected level keeps a freshly reset monitor from seeing a fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= rst_val;
            q    <= rst_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gtech_tie_monitor.sv
// rtl/gtech_tie_monitor.sv - tie-off net checker; GTECH_TIE_MON_INJECT_EN adds the INJ fault-injection port
module gtech_tie_monitor
    import gtech_tie_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] EXPECT   = '0,
    parameter int               DEBOUNCE = 2,
    parameter int               CNT_W    = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] TIE_IN,
    input  logic             CLR,
    output logic             MISMATCH,
    output logic             ERR,
    output logic [WIDTH-1:0] ERR_MASK,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic             ERR_EVT
`ifdef GTECH_TIE_MON_INJECT_EN
    ,
    input  logic [WIDTH-1:0] INJ
`endif
);

    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE);

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] conf;
    logic [DB_W-1:0]  db_cnt [WIDTH];
    logic             evt;
    tie_state_t       state, state_nxt;

    gtech_tie_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk     (CLK),
        .rst     (RST),
        .rst_val (EXPECT),
        .d       (TIE_IN),
        .q       (sync_out)
    );

`ifdef GTECH_TIE_MON_INJECT_EN
    assign m = sync_out ^ EXPECT ^ INJ;
`else
    assign m = sync_out ^ EXPECT;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (EN && m[i]) begin
                    if (db_cnt[i] != DB_MAX) db_cnt[i] <= db_cnt[i] + 1'b1;
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        c = '0;
        for (int i = 0; i < WIDTH; i++) c[i] = (db_cnt[i] == DB_MAX);
    end

    // Counters still hold their value for the cycle EN drops; mask them so nothing latches then.
    assign conf = EN ? c : '0;

    always_comb begin
        state_nxt = state;
        evt       = 1'b0;
        case (state)
            DISABLED: if (EN) state_nxt = CLEAN;
            CLEAN: begin
                if (|conf) begin
                    state_nxt = FAULT;
                    evt       = 1'b1;
                end
            end
            FAULT:    if (!(|conf)) state_nxt = CLEAN;
            default:  state_nxt = DISABLED;
        endcase
        if (!EN) begin
            state_nxt = DISABLED;
            evt       = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= DISABLED;
            MISMATCH <= 1'b0;
            ERR_EVT  <= 1'b0;
            ERR_MASK <= '0;
            ERR_CNT  <= '0;
        end else begin
            state    <= state_nxt;
            MISMATCH <= |conf;
            ERR_EVT  <= evt;
            // A clear coinciding with a new event keeps that event visible.
            if (CLR) begin
                ERR_MASK <= evt ? conf : '0;
                ERR_CNT  <= evt ? CNT_W'(1) : '0;
            end else begin
                ERR_MASK <= ERR_MASK | conf;
                if (evt && (ERR_CNT != {CNT_W{1'b1}})) ERR_CNT <= ERR_CNT + 1'b1;
            end
        end
    end

    assign ERR = |ERR_MASK;

endmodule
